// File: rtl/sync_filter_edge.sv
// rtl/sync_filter_edge.sv - multi-channel CDC synchronizer with glitch filter and edge pulses
// Each bit is synchronized, must hold a new value for FILTER_CYCLES edges, then reports rise/fall.
module sync_filter_edge #(
   parameter int               WIDTH         = 1,
   parameter int               STAGES        = 2,
   parameter int               FILTER_CYCLES = 4,
   parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             any_edge
);

   localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

   if (STAGES < 2) begin : g_bad_stages
      $error("sync_filter_edge: STAGES must be >= 2");
   end
   if (FILTER_CYCLES < 1) begin : g_bad_filter
      $error("sync_filter_edge: FILTER_CYCLES must be >= 1");
   end

   logic [WIDTH-1:0] sync_q [STAGES];
   logic [CNT_W-1:0] cnt_q  [WIDTH];
   logic [CNT_W-1:0] cnt_d  [WIDTH];
   logic [WIDTH-1:0] dout_q, dout_d;
   logic [WIDTH-1:0] rise_q, rise_d;
   logic [WIDTH-1:0] fall_q, fall_d;
   logic             any_edge_q;
   logic [WIDTH-1:0] s;

   assign s = sync_q[STAGES-1];

   // Pure flop chain: no logic between stages so metastability has full cycles to resolve.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) sync_q[k] <= RESET_VAL;
      end else begin
         sync_q[0] <= din;
         for (int k = 1; k < STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
   end

   always_comb begin
      dout_d = dout_q;
      rise_d = '0;
      fall_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (s[i] == dout_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            dout_d[i] = s[i];
            rise_d[i] = s[i];
            fall_d[i] = ~s[i];
            cnt_d[i]  = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
         dout_q     <= RESET_VAL;
         rise_q     <= '0;
         fall_q     <= '0;
         any_edge_q <= 1'b0;
      end else begin
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
         dout_q     <= dout_d;
         rise_q     <= rise_d;
         fall_q     <= fall_d;
         any_edge_q <= |(rise_d | fall_d);
      end
   end

   assign dout     = dout_q;
   assign rise     = rise_q;
   assign fall     = fall_q;
   assign any_edge = any_edge_q;

endmodule

// File: tb/tb_sync_filter_edge.sv
// tb/tb_sync_filter_edge.sv - bench for sync_filter_edge
// Window-based reference model for the 4-channel instance plus directed literal checks.
module tb_sync_filter_edge;

   localparam int         W  = 4;
   localparam int         ST = 3;
   localparam int         FC = 4;
   localparam logic [3:0] RV = 4'h0;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] din = 4'hF;
   logic [3:0] dout, rise, fall;
   logic       any_edge;

   logic       din2 = 1'b0;
   logic       dout2, rise2, fall2, any2;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   sync_filter_edge #(.WIDTH(W), .STAGES(ST), .FILTER_CYCLES(FC), .RESET_VAL(RV)) dut (
      .clk(clk), .rst(rst), .din(din),
      .dout(dout), .rise(rise), .fall(fall), .any_edge(any_edge)
   );

   sync_filter_edge #(.WIDTH(1), .STAGES(2), .FILTER_CYCLES(1), .RESET_VAL(1'b0)) dut_min (
      .clk(clk), .rst(rst), .din(din2),
      .dout(dout2), .rise(rise2), .fall(fall2), .any_edge(any2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: s seen at edge n is din sampled STAGES edges earlier; dout flips once the
   // last FC presented values all differ from it and FC edges have passed since its last change.
   logic [3:0] din_hist [$];
   logic [3:0] s_hist   [$];
   logic [3:0] dout_m = RV, rise_m = '0, fall_m = '0;
   logic       any_m = 1'b0;
   int         last_chg [W];
   int         n_edges = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         din_hist.delete();
         s_hist.delete();
         dout_m  <= RV;
         rise_m  <= '0;
         fall_m  <= '0;
         any_m   <= 1'b0;
         n_edges <= 0;
         for (int i = 0; i < W; i++) last_chg[i] <= 0;
      end else begin
         automatic int         n = n_edges + 1;
         automatic logic [3:0] s_pre = RV;
         automatic logic [3:0] nd = dout_m;
         automatic logic [3:0] r = '0;
         automatic logic [3:0] f = '0;
         automatic bit         all_diff;
         if (din_hist.size() >= ST) s_pre = din_hist[din_hist.size() - ST];
         din_hist.push_back(din);
         s_hist.push_back(s_pre);
         for (int i = 0; i < W; i++) begin
            all_diff = (n - last_chg[i]) >= FC;
            for (int j = 0; j < FC; j++)
               if (all_diff && s_hist[s_hist.size() - 1 - j][i] == dout_m[i]) all_diff = 1'b0;
            if (all_diff) begin
               nd[i] = ~dout_m[i];
               r[i]  = ~dout_m[i];
               f[i]  = dout_m[i];
               last_chg[i] <= n;
            end
         end
         dout_m  <= nd;
         rise_m  <= r;
         fall_m  <= f;
         any_m   <= |(r | f);
         n_edges <= n;
      end
   end

   always @(negedge clk) begin
      chk("model_dout", dout, dout_m);
      chk("model_rise", rise, rise_m);
      chk("model_fall", fall, fall_m);
      chk("model_any", any_edge, any_m);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] v);
      @(negedge clk);
      din = v;
   endtask

   task automatic settle(input logic [3:0] v);
      drive(v);
      repeat (12) step();
   endtask

   initial begin
      bit bad;

      // 1. reset held with din=F, then release
      repeat (3) step();
      chk("rst_dout", dout, 4'h0);
      chk("rst_rise", rise, 4'h0);
      chk("rst_fall", fall, 4'h0);
      chk("rst_any", any_edge, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         step();
         if (k == 6) chk("rel_dout_e6", dout, 4'h0);
         if (k == 7) begin
            chk("rel_dout_e7", dout, 4'hF);
            chk("rel_rise_e7", rise, 4'hF);
            chk("rel_any_e7", any_edge, 1'b1);
         end
      end
      step();
      chk("rel_rise_e8", rise, 4'h0);
      chk("rel_any_e8", any_edge, 1'b0);

      // 2. glitch rejection: 3-cycle pulse ignored, 4-cycle pulse accepted
      settle(4'h0);
      drive(4'h1);
      repeat (2) @(negedge clk);
      drive(4'h0);
      bad = 1'b0;
      repeat (20) begin
         step();
         if (dout !== 4'h0 || rise !== 4'h0 || fall !== 4'h0 || any_edge !== 1'b0) bad = 1'b1;
      end
      chk("glitch3_quiet", bad, 1'b0);
      drive(4'h1);
      for (int k = 1; k <= 7; k++) begin
         step();
         if (k == 7) begin
            chk("glitch4_dout", dout, 4'h1);
            chk("glitch4_rise", rise, 4'h1);
         end
         if (k == 4) begin
            @(negedge clk);
            din = 4'h0;
         end
      end
      repeat (15) step();

      // 3. falling then rising edge on channel 2
      settle(4'hF);
      drive(4'hB);
      for (int k = 1; k <= 10; k++) begin
         step();
         if (k == 7) begin
            chk("fall2_dout", dout, 4'hB);
            chk("fall2_fall", fall, 4'h4);
            chk("fall2_rise", rise, 4'h0);
         end
      end
      drive(4'hF);
      for (int k = 1; k <= 7; k++) begin
         step();
         if (k == 7) begin
            chk("rise2_dout", dout, 4'hF);
            chk("rise2_rise", rise, 4'h4);
         end
      end

      // 4. simultaneous opposite edges
      settle(4'h2);
      drive(4'h1);
      for (int k = 1; k <= 7; k++) begin
         step();
         if (k == 6) chk("simul_dout_e6", dout, 4'h2);
         if (k == 7) begin
            chk("simul_dout", dout, 4'h1);
            chk("simul_rise", rise, 4'h1);
            chk("simul_fall", fall, 4'h2);
            chk("simul_any", any_edge, 1'b1);
         end
      end

      // 5. reset while channel 3 counter is mid-window
      settle(4'h0);
      drive(4'h8);
      repeat (5) step();
      #1 rst = 1'b1;
      #1;
      chk("midrst_dout", dout, 4'h0);
      chk("midrst_rise", rise, 4'h0);
      chk("midrst_fall", fall, 4'h0);
      chk("midrst_any", any_edge, 1'b0);
      repeat (2) step();
      @(negedge clk);
      rst = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         step();
         if (k == 6) begin
            chk("midrst_dout_e6", dout, 4'h0);
            chk("midrst_rise_e6", rise, 4'h0);
         end
         if (k == 7) begin
            chk("midrst_dout_e7", dout, 4'h8);
            chk("midrst_rise_e7", rise, 4'h8);
         end
      end

      // 6. minimum configuration instance
      @(negedge clk);
      din2 = 1'b1;
      step();
      step();
      chk("min_dout_e2", dout2, 1'b0);
      step();
      chk("min_dout_e3", dout2, 1'b1);
      chk("min_rise_e3", rise2, 1'b1);
      chk("min_any_e3", any2, 1'b1);
      step();
      chk("min_rise_e4", rise2, 1'b0);
      chk("min_dout_e4", dout2, 1'b1);
      @(negedge clk);
      din2 = 1'b0;
      repeat (5) step();
      chk("min_back0", dout2, 1'b0);
      @(negedge clk);
      din2 = 1'b1;
      @(negedge clk);
      din2 = 1'b0;
      step();
      step();
      chk("min_pulse_dout_e3", dout2, 1'b1);
      chk("min_pulse_rise_e3", rise2, 1'b1);
      step();
      chk("min_pulse_dout_e4", dout2, 1'b0);
      chk("min_pulse_fall_e4", fall2, 1'b1);
      chk("min_pulse_rise_e4", rise2, 1'b0);

      repeat (2) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
